// File: rtl/calc_io_ctrl.sv
// Keypad-to-CPU handoff controller: collects two BCD operands and an operator,
// converts operands to binary, writes them to CPU memory, runs the CPU and holds its result.
module calc_io_ctrl #(
  parameter int unsigned DIGITS      = 2,
  parameter logic [31:0] DONE_INSTR  = 32'hFFFF_FFFF,
  parameter logic [31:0] ADDR_NUM1   = 32'd220,
  parameter logic [31:0] ADDR_NUM2   = 32'd240,
  parameter logic [31:0] ADDR_OP     = 32'd260,
  parameter logic [31:0] ADDR_RESULT = 32'd280,
  parameter logic [31:0] ADDR_IDLE   = 32'd320,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  key_strobe,
  input  logic [4:0]            key_code,
  input  logic [31:0]           instruction,
  input  logic [31:0]           data_in,
  output logic [31:0]           address,
  output logic [31:0]           data_out,
  output logic                  fpga_en,
  output logic                  fpga_write,
  output logic                  cpu_en,
  output logic                  nrst_fpga,
  output logic [8*DIGITS-1:0]   disp,
  output logic                  disp_en,
  output logic [2:0]            state_o
);

  localparam int unsigned DW  = 4 * DIGITS;
  localparam int unsigned DSW = 8 * DIGITS;
  localparam int unsigned CW  = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);
  localparam logic [CW-1:0] CI_LAST  = CW'(DIGITS - 1);
  localparam logic [31:0]   TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_NUM1    = 3'd0,
    S_OPSEL   = 3'd1,
    S_NUM2    = 3'd2,
    S_CONV    = 3'd3,
    S_WR      = 3'd4,
    S_RUN     = 3'd5,
    S_RDRES   = 3'd6,
    S_DISPLAY = 3'd7
  } state_e;

  typedef enum logic [1:0] {TGT_NUM1, TGT_OP, TGT_NUM2} tgt_e;

  state_e        state_q, state_d;
  tgt_e          tgt_q, tgt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ci_q, ci_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   result_q, result_d;
  logic [31:0]   tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          nrst_fpga_q, nrst_fpga_d;

  logic isDigit, isEnter, isClear, isBack, isOp;

  assign isDigit = key_code <= 5'd9;
  assign isEnter = key_code == 5'd12;
  assign isClear = key_code == 5'd13;
  assign isBack  = key_code == 5'd14;
  assign isOp    = key_code[4:2] == 3'b100;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_NUM1;
      tgt_q       <= TGT_NUM1;
      dig_q       <= '0;
      cnt_q       <= '0;
      ci_q        <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      nrst_fpga_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      ci_q        <= ci_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      nrst_fpga_q <= nrst_fpga_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    ci_d        = ci_q;
    op_d        = op_q;
    acc_d       = acc_q;
    result_d    = result_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    nrst_fpga_d = 1'b1;
    address     = ADDR_IDLE;
    data_out    = '0;
    fpga_en     = 1'b1;
    fpga_write  = 1'b0;
    cpu_en      = 1'b0;
    disp        = '0;
    disp_en     = 1'b0;

    case (state_q)
      S_NUM1, S_NUM2: begin
        disp_en = 1'b1;
        disp    = DSW'(dig_q);
        if (key_strobe) begin
          if (isDigit) begin
            if (cnt_q != CNT_MAX) begin
              dig_d = (dig_q << 4) | DW'(key_code[3:0]);
              cnt_d = cnt_q + CW'(1);
            end
          end else if (isBack) begin
            if (cnt_q != '0) begin
              dig_d = dig_q >> 4;
              cnt_d = cnt_q - CW'(1);
            end
          end else if (isClear) begin
            dig_d = '0;
            cnt_d = '0;
          end else if (isEnter) begin
            acc_d   = '0;
            ci_d    = CI_LAST;
            tgt_d   = (state_q == S_NUM1) ? TGT_NUM1 : TGT_NUM2;
            state_d = S_CONV;
          end
        end
      end
      S_OPSEL: begin
        disp_en = 1'b1;
        disp    = DSW'(op_q);
        if (key_strobe) begin
          if (isOp) begin
            op_d = key_code[1:0];
          end else if (isEnter) begin
            tgt_d   = TGT_OP;
            state_d = S_WR;
          end
        end
      end
      // Most significant digit first; unused leading digits are zero and harmless.
      S_CONV: begin
        acc_d = acc_q * 32'd10 + 32'(dig_q[4*ci_q +: 4]);
        if (ci_q == '0) begin
          state_d = S_WR;
        end else begin
          ci_d = ci_q - CW'(1);
        end
      end
      S_WR: begin
        fpga_write = 1'b1;
        dig_d      = '0;
        cnt_d      = '0;
        case (tgt_q)
          TGT_NUM1: begin
            address  = ADDR_NUM1;
            data_out = acc_q;
            state_d  = S_OPSEL;
          end
          TGT_OP: begin
            address  = ADDR_OP;
            data_out = {30'b0, op_q};
            state_d  = S_NUM2;
          end
          default: begin
            address  = ADDR_NUM2;
            data_out = acc_q;
            tmo_d    = '0;
            state_d  = S_RUN;
          end
        endcase
      end
      // Completion wins over a timeout expiring on the same edge.
      S_RUN: begin
        cpu_en  = 1'b1;
        fpga_en = 1'b0;
        if (instruction == DONE_INSTR) begin
          state_d = S_RDRES;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DISPLAY;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_RDRES: begin
        address  = ADDR_RESULT;
        result_d = data_in;
        state_d  = S_DISPLAY;
      end
      S_DISPLAY: begin
        disp_en = 1'b1;
        disp    = err_q ? '1 : DSW'(result_q);
        if (key_strobe && (isEnter || isClear)) begin
          nrst_fpga_d = 1'b0;
          err_d       = 1'b0;
          state_d     = S_NUM1;
        end
      end
      default: state_d = S_NUM1;
    endcase
  end

  assign nrst_fpga = nrst_fpga_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_calc_io_ctrl.sv
// Randomised bench for calc_io_ctrl; expected values come from a digit-queue model
// of the keypad entry and a decimal conversion done with plain arithmetic.
module tb_calc_io_ctrl;

  localparam int DIGITS  = 2;
  localparam int TIMEOUT = 16;
  localparam int DW      = 8 * DIGITS;
  localparam logic [31:0] DONE = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          key_strobe = 1'b0;
  logic [4:0]    key_code = 5'd0;
  logic [31:0]   instruction = 32'd0;
  logic [31:0]   data_in = 32'd0;
  logic [31:0]   address, data_out;
  logic          fpga_en, fpga_write, cpu_en, nrst_fpga, disp_en;
  logic [DW-1:0] disp;
  logic [2:0]    state_o;

  int vectors = 0;
  int miscompares = 0;
  int digs[$];
  int modelOp = 0;

  always #5 clk = ~clk;

  calc_io_ctrl #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .key_strobe(key_strobe), .key_code(key_code),
    .instruction(instruction), .data_in(data_in), .address(address),
    .data_out(data_out), .fpga_en(fpga_en), .fpga_write(fpga_write),
    .cpu_en(cpu_en), .nrst_fpga(nrst_fpga), .disp(disp), .disp_en(disp_en),
    .state_o(state_o)
  );

  function automatic logic [31:0] modelPacked();
    logic [31:0] p = 32'd0;
    foreach (digs[i]) p = (p << 4) | 32'(digs[i]);
    return p;
  endfunction

  function automatic logic [31:0] modelValue();
    logic [31:0] v = 32'd0;
    foreach (digs[i]) v = v * 10 + 32'(digs[i]);
    return v;
  endfunction

  function automatic void modelKey(input logic [4:0] code);
    if (code <= 5'd9) begin
      if (digs.size() < DIGITS) digs.push_back(int'(code));
    end else if (code == 5'd14) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (code == 5'd13) begin
      digs.delete();
    end
  endfunction

  task automatic pressKey(input logic [4:0] code);
    @(negedge clk);
    key_strobe = 1'b1;
    key_code   = code;
    @(negedge clk);
    key_strobe = 1'b0;
    key_code   = 5'd0;
  endtask

  task automatic keyChecked(input logic [4:0] code);
    modelKey(code);
    pressKey(code);
    vectors++;
    if (disp !== DW'(modelPacked())) begin
      miscompares++;
      $display("FAIL entry disp after key %0d: got %h, want %h", code, disp, DW'(modelPacked()));
    end
  endtask

  task automatic typeOperand();
    int ign[6] = '{10, 11, 15, 16, 19, 27};
    int n = $urandom_range(1, 7);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [4:0] code;
      r = $urandom_range(0, 9);
      if (r < 6) code = 5'($urandom_range(0, 9));
      else if (r < 8) code = 5'd14;
      else if (r == 8) code = 5'd13;
      else code = 5'(ign[$urandom_range(0, 5)]);
      keyChecked(code);
    end
  endtask

  task automatic enterAndWrite(input logic [31:0] expAddr, input logic [31:0] expData,
                               input int expLatency, input logic [2:0] expNext, input string name);
    int lat = 0;
    pressKey(5'd12);
    while (fpga_write !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== expLatency) begin
      miscompares++;
      $display("FAIL %s write latency: got %0d, want %0d", name, lat, expLatency);
    end
    vectors++;
    if (address !== expAddr || fpga_en !== 1'b1) begin
      miscompares++;
      $display("FAIL %s write addr/en: got %0d/%b, want %0d/1", name, address, fpga_en, expAddr);
    end
    vectors++;
    if (data_out !== expData) begin
      miscompares++;
      $display("FAIL %s write data: got %0d, want %0d", name, data_out, expData);
    end
    @(negedge clk);
    vectors++;
    if (state_o !== expNext || fpga_write !== 1'b0) begin
      miscompares++;
      $display("FAIL %s next state: got %0d wr=%b, want %0d wr=0", name, state_o, fpga_write, expNext);
    end
  endtask

  task automatic finishRun(input int waitCycles, input logic [31:0] res);
    vectors++;
    if ({state_o, cpu_en, fpga_en, address} !== {3'd5, 1'b1, 1'b0, 32'd320}) begin
      miscompares++;
      $display("FAIL run outputs: got st=%0d cpu=%b en=%b addr=%0d, want 5 1 0 320",
               state_o, cpu_en, fpga_en, address);
    end
    data_in = res;
    repeat (waitCycles) @(negedge clk);
    instruction = DONE;
    @(negedge clk);
    instruction = 32'd0;
    vectors++;
    if ({state_o, address, fpga_en, fpga_write, cpu_en} !== {3'd6, 32'd280, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rdres outputs: got st=%0d addr=%0d en=%b wr=%b cpu=%b, want 6 280 1 0 0",
               state_o, address, fpga_en, fpga_write, cpu_en);
    end
    @(negedge clk);
    vectors++;
    if (state_o !== 3'd7 || disp_en !== 1'b1 || disp !== res[DW-1:0]) begin
      miscompares++;
      $display("FAIL display result: got st=%0d en=%b disp=%h, want 7 1 %h", state_o, disp_en, disp, res[DW-1:0]);
    end
  endtask

  task automatic leaveDisplay(input logic [4:0] code);
    pressKey(code);
    vectors++;
    if (state_o !== 3'd0 || nrst_fpga !== 1'b0) begin
      miscompares++;
      $display("FAIL leave display: got st=%0d nrst_fpga=%b, want 0 0", state_o, nrst_fpga);
    end
    @(negedge clk);
    vectors++;
    if (state_o !== 3'd0 || nrst_fpga !== 1'b1) begin
      miscompares++;
      $display("FAIL nrst_fpga pulse width: got st=%0d nrst_fpga=%b, want 0 1", state_o, nrst_fpga);
    end
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #2;
    vectors++;
    if ({state_o, address, data_out, fpga_en, fpga_write, cpu_en, nrst_fpga, disp, disp_en} !==
        {3'd0, 32'd320, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, DW'(0), 1'b1}) begin
      miscompares++;
      $display("FAIL reset outputs: got st=%0d addr=%0d dout=%0d en=%b wr=%b cpu=%b nf=%b disp=%h de=%b",
               state_o, address, data_out, fpga_en, fpga_write, cpu_en, nrst_fpga, disp, disp_en);
    end
    @(negedge clk);
    nrst = 1'b1;
    digs.delete();
    modelOp = 0;
  endtask

  task automatic test_digit_entry();
    keyChecked(5'd1);
    keyChecked(5'd2);
    keyChecked(5'd3);
    keyChecked(5'd14);
    keyChecked(5'd7);
    vectors++;
    if (disp !== DW'(16'h0017)) begin
      miscompares++;
      $display("FAIL overflow/backspace disp: got %h, want 0017", disp);
    end
    keyChecked(5'd14);
    keyChecked(5'd14);
    keyChecked(5'd14);
    keyChecked(5'd4);
    keyChecked(5'd2);
    enterAndWrite(32'd220, 32'd42, DIGITS, 3'd1, "num1 42");
    digs.delete();
  endtask

  task automatic test_operator();
    logic [4:0] keys[3] = '{5'd18, 5'd17, 5'd5};
    int expOp[3] = '{2, 1, 1};
    vectors++;
    if (disp !== DW'(modelOp)) begin
      miscompares++;
      $display("FAIL opsel initial disp: got %h, want %h", disp, DW'(modelOp));
    end
    for (int i = 0; i < 3; i++) begin
      pressKey(keys[i]);
      modelOp = expOp[i];
      vectors++;
      if (disp !== DW'(modelOp)) begin
        miscompares++;
        $display("FAIL opsel disp after key %0d: got %h, want %h", keys[i], disp, DW'(modelOp));
      end
    end
    enterAndWrite(32'd260, 32'(modelOp), 0, 3'd2, "op write");
    keyChecked(5'd9);
    enterAndWrite(32'd240, 32'd9, DIGITS, 3'd5, "num2 9");
    digs.delete();
    finishRun(TIMEOUT - 1, 32'h0000_0033);
    leaveDisplay(5'd12);
  endtask

  task automatic test_done_outside_run();
    instruction = DONE;
    keyChecked(5'd5);
    repeat (3) @(negedge clk);
    vectors++;
    if (state_o !== 3'd0 || disp !== DW'(16'h0005)) begin
      miscompares++;
      $display("FAIL done outside run: got st=%0d disp=%h, want 0 0005", state_o, disp);
    end
    instruction = 32'd0;
    keyChecked(5'd13);
  endtask

  task automatic test_reset_mid_conv();
    keyChecked(5'd3);
    keyChecked(5'd8);
    pressKey(5'd12);
    vectors++;
    if (state_o !== 3'd3) begin
      miscompares++;
      $display("FAIL conv entry: got st=%0d, want 3", state_o);
    end
    #2 nrst = 1'b0;
    #1;
    vectors++;
    if ({state_o, fpga_write, address, disp} !== {3'd0, 1'b0, 32'd320, DW'(0)}) begin
      miscompares++;
      $display("FAIL async abort: got st=%0d wr=%b addr=%0d disp=%h, want 0 0 320 0",
               state_o, fpga_write, address, disp);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (fpga_write !== 1'b0 || state_o !== 3'd0) begin
        miscompares++;
        $display("FAIL write during reset: got wr=%b st=%0d, want 0 0", fpga_write, state_o);
      end
    end
    nrst = 1'b1;
    digs.delete();
    modelOp = 0;
    enterAndWrite(32'd220, 32'd0, DIGITS, 3'd1, "empty num1");
    vectors++;
    if (disp !== DW'(0)) begin
      miscompares++;
      $display("FAIL op after reset: got %h, want 0", disp);
    end
    enterAndWrite(32'd260, 32'd0, 0, 3'd2, "op after reset");
    enterAndWrite(32'd240, 32'd0, DIGITS, 3'd5, "empty num2");
    finishRun(2, 32'hABCD_5A5A);
    leaveDisplay(5'd13);
  endtask

  task automatic test_timeout();
    int runCycles = 0;
    typeOperand();
    enterAndWrite(modelValue() == modelValue() ? 32'd220 : 32'd0, modelValue(), DIGITS, 3'd1, "tmo num1");
    digs.delete();
    pressKey(5'd19);
    modelOp = 3;
    enterAndWrite(32'd260, 32'd3, 0, 3'd2, "tmo op");
    typeOperand();
    enterAndWrite(32'd240, modelValue(), DIGITS, 3'd5, "tmo num2");
    digs.delete();
    while (state_o === 3'd5 && runCycles < 100) begin
      runCycles++;
      @(negedge clk);
    end
    vectors++;
    if (runCycles !== TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout run length: got %0d, want %0d", runCycles, TIMEOUT);
    end
    vectors++;
    if (state_o !== 3'd7 || disp !== {DW{1'b1}}) begin
      miscompares++;
      $display("FAIL timeout display: got st=%0d disp=%h, want 7 %h", state_o, disp, {DW{1'b1}});
    end
    leaveDisplay(5'd13);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      int nOps;
      logic [31:0] res;
      typeOperand();
      enterAndWrite(32'd220, modelValue(), DIGITS, 3'd1, "b2b num1");
      digs.delete();
      nOps = $urandom_range(1, 3);
      for (int k = 0; k < nOps; k++) begin
        logic [4:0] code;
        code = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 9)) : 5'(16 + $urandom_range(0, 3));
        if (k == 0) code = 5'(16 + $urandom_range(0, 3));
        pressKey(code);
        if (code >= 5'd16) modelOp = int'(code) - 16;
        vectors++;
        if (disp !== DW'(modelOp)) begin
          miscompares++;
          $display("FAIL b2b opsel disp: got %h, want %h", disp, DW'(modelOp));
        end
      end
      enterAndWrite(32'd260, 32'(modelOp), 0, 3'd2, "b2b op");
      typeOperand();
      enterAndWrite(32'd240, modelValue(), DIGITS, 3'd5, "b2b num2");
      digs.delete();
      res = $urandom;
      finishRun($urandom_range(0, TIMEOUT - 2), res);
      leaveDisplay(($urandom_range(0, 1) == 0) ? 5'd12 : 5'd13);
    end
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_operator();
    test_done_outside_run();
    test_reset_mid_conv();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/calc_io_ctrl.md
# calc_io_ctrl

Parametrised keypad/CPU handoff controller for the calculator front end. It collects two decimal operands of up to DIGITS digits and an operator from debounced keypad strobes, and converts each operand to binary. It writes the operands and operator into CPU-visible memory, runs the CPU until the done instruction appears, then reads and holds the result for the seven-segment display. It sits between keysync/edgeDetector and the CPU data bus.

## Interface
Parameters:
- DIGITS, 2: BCD digits per operand; legal range 1..9.
- DONE_INSTR, 32'hFFFF_FFFF: instruction word that signals CPU completion.
- ADDR_NUM1 / ADDR_NUM2 / ADDR_OP / ADDR_RESULT / ADDR_IDLE, 220 / 240 / 260 / 280 / 320: bus addresses.
- TIMEOUT, 1_000_000: maximum number of RUN cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- nrst  in  1  asynchronous, active-low reset.
- key_strobe  in  1  one-cycle pulse per key press (already edge-detected).
- key_code  in  5  key code: 0–9 digit, 12 enter, 13 clear, 14 backspace, 16–19 operator (op = key_code[1:0]); all other codes are ignored.
- instruction  in  32  instruction currently being fetched by the CPU.
- data_in  in  32  bus read data, combinationally valid for the current address.
- address  out  32  bus address.
- data_out  out  32  bus write data.
- fpga_en, fpga_write, cpu_en, nrst_fpga  out  1 each  bus-ownership and control strobes.
- disp  out  8*DIGITS  nibble-packed display value.
- disp_en  out  1  display enable.
- state_o  out  3  current state, for debug LEDs.

## Operation
- States: NUM1=0, OPSEL=1, NUM2=2, CONV=3, WR=4, RUN=5, RDRES=6, DISPLAY=7. A timeout sets the error flag `err` and returns to DISPLAY with an error indication.
- Entry registers: `dig` holds DIGITS×4 bits of BCD; `cnt` is a 0..DIGITS counter; `op` is 2 bits; `tgt` selects NUM1, OP or NUM2.
- Key handling is active only in NUM1, NUM2, OPSEL and DISPLAY. Strobes arriving in any other state are dropped.
- Digit key in NUM1 or NUM2: when cnt<DIGITS, `dig <= {dig<<4 | code}` and cnt++. When cnt==DIGITS the key is ignored; no digits are lost.
- Backspace: `dig >>= 4` and cnt--. It is a no-op when cnt==0.
- Clear: dig=0 and cnt=0. In DISPLAY, clear behaves like enter.
- Operator key in OPSEL: op <= code[1:0]. Repeated operator keys overwrite op.
- Enter:
  - NUM1 or NUM2: go to CONV.
  - OPSEL: go directly to WR with data_out={30'b0,op}.
  - Enter with cnt==0 converts to the value 0.
- CONV: acc=0 at entry, then `acc <= acc*10 + next digit`, most significant digit first, taking exactly DIGITS cycles. Leading zeros of unused digits are harmless. acc is 32 bits; DIGITS≤9 guarantees no overflow.
- WR (one cycle): address=ADDR_{tgt}, data_out=acc or op, fpga_en=1, fpga_write=1. After WR, dig and cnt are cleared and the next state is:
  - NUM1 → OPSEL
  - OP → NUM2
  - NUM2 → RUN
- RUN: cpu_en=1, fpga_en=0, fpga_write=0, address=ADDR_IDLE.
  - instruction==DONE_INSTR → RDRES.
  - A cycle counter reaching TIMEOUT → DISPLAY with err=1 and result=0.
- RDRES (one cycle): address=ADDR_RESULT, fpga_en=1, fpga_write=0. result<=data_in is sampled at the end of the cycle. Next state is DISPLAY.
- DISPLAY: enter or clear pulses nrst_fpga=0 for exactly one cycle, clears err, and returns to NUM1.
- Default outputs in all states: address=ADDR_IDLE, data_out=0, fpga_en=1, fpga_write=0, cpu_en=0, nrst_fpga=1.
- disp contents:
  - NUM1/NUM2: {zeros, dig}.
  - OPSEL: {zeros, 2'b0, op}.
  - DISPLAY: result[8*DIGITS-1:0] as hex nibbles, or all 1s when err.
- disp_en is 1 in NUM1, OPSEL, NUM2 and DISPLAY.

## Timing
- Reset (asynchronous): state=NUM1; dig, cnt, op, acc, result, err and the timeout counter all 0; outputs at their defaults.
- Key strobe sampled at edge t takes effect at t+1.
- Enter in NUM1 or NUM2 at edge t:
  - CONV occupies cycles t+1..t+DIGITS.
  - WR occurs in cycle t+DIGITS+1.
  - The next state is entered at t+DIGITS+2.
- Enter in OPSEL at t: WR at t+1.
- DONE_INSTR seen in RUN at edge t: RDRES in cycle t+1, DISPLAY at t+2.
- DONE_INSTR outside RUN is ignored.
- A timeout firing on the same edge as DONE takes DONE; err stays 0.
- Asserting reset mid-CONV, mid-WR or mid-RUN aborts immediately, with no partial write visible after nrst falls.

## Test plan
- DIGITS=2, keys 4,2,enter → one WR cycle with address=220 and data_out=42, then state OPSEL.
- Keys 1,2,3 with DIGITS=2, then backspace, then 7 → dig=0x17, cnt=2, disp=0x17.
- Operator 18 then 17, enter → address=260, data_out=1; NUM2 9,enter → address=240, data_out=9, then RUN with cpu_en=1.
- In RUN, drive instruction=FFFF_FFFF with data_in=0x0000_0033 at RDRES → DISPLAY with disp=0x0033 and disp_en=1; enter → one-cycle nrst_fpga low, then NUM1.
- TIMEOUT=16 with no DONE → DISPLAY after 16 RUN cycles, err=1, disp all 1s.
- Reset asserted during CONV with DIGITS=9 → state 0, fpga_write never pulses, all registers zero.
